id_hazard_scoreboard: RTL and testbench
=======================================

# id_hazard_scoreboard

Parametrised ID-stage operand-hazard unit, successor to the two-port ID forwarding mux. Serves NUM_RPORTS read ports: forwards from EX/MEM/WB, and tracks multi-cycle producers (loads, mul/div) in a per-register countdown scoreboard. Stalls ID until every used operand is forwardable. Sits between the register file read ports and the ID/EX pipeline register.

## Interface
Parameters:
- NUM_RPORTS, 2: number of operand read ports (1..4)
- DW, 32: data width
- AW, 5: register address width; register 0 is hard zero
- MAX_LAT, 7: largest issue latency; counter width is clog2(MAX_LAT+1)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- rd_addr_i  in  NUM_RPORTS*AW  read addresses, port p at [p*AW +: AW]
- rd_used_i  in  NUM_RPORTS  port p operand is consumed by the ID instruction
- rf_rdata_i  in  NUM_RPORTS*DW  register file read data
- rdata_o  out  NUM_RPORTS*DW  resolved operands
- branch_i  in  1  ID instruction is a branch/jr that resolves in ID
- ex_we_i, ex_waddr_i, ex_wdata_i, ex_vld_i  in  1/AW/DW/1  EX producer; vld=0 means result not yet computed (load, mul/div)
- mem_we_i, mem_waddr_i, mem_wdata_i, mem_vld_i  in  1/AW/DW/1  MEM producer
- wb_we_i, wb_waddr_i, wb_wdata_i  in  1/AW/DW  WB producer, always valid
- issue_i  in  1  ID instruction moves to EX this cycle
- issue_we_i, issue_waddr_i  in  1/AW  destination of the issuing instruction
- issue_lat_i  in  3  cycles until issued result is forwardable (0 = single-cycle ALU)
- hold_i  in  1  pipeline frozen downstream; counters do not decrement
- flush_i  in  1  pipeline flush; clears scoreboard
- stall_o  out  1  ID must not issue
- stall_why_o  out  3  {branch_ex, load_use, scoreboard}
- perf_stall_cnt_o  out  32  cycles with stall_o=1
- perf_lu_cnt_o  out  32  cycles with load_use stall

## Operation
- Per port p, when rst_i=1: rdata_o[p]=0. Else if rd_addr=0: rf_rdata. Else first match of: EX (we, addr eq, vld) -> ex_wdata; MEM (we, addr eq, vld) -> mem_wdata; WB (we, addr eq) -> wb_wdata; else rf_rdata.
- An invalid EX/MEM match does NOT fall through to older stages; it raises load_use instead.
- load_use: some used port, addr≠0, matches EX or MEM with we=1 and vld=0.
- branch_ex: branch_i=1 and some used port, addr≠0, matches EX with ex_we_i=1 (no EX forwarding to ID compare).
- scoreboard: some used port, addr≠0, has cnt[addr]≠0.
- stall_o = OR of three reasons; stall_why_o shows all active reasons simultaneously.
- Scoreboard: cnt[1..2^AW-1], reset 0. Priority per edge: rst_i > flush_i > issue write > decrement.
  - issue_i & issue_we_i & waddr≠0: cnt[waddr] <= issue_lat_i (overwrites pending value, WAW).
  - All other nonzero counters decrement by 1 when hold_i=0; saturate at 0.
  - issue_lat_i > MAX_LAT is clamped to MAX_LAT.
- issue_i while stall_o=1 is a protocol error; block still records it.

## Timing
- rdata_o, stall_o, stall_why_o combinational from inputs and registered counters; zero latency.
- Scoreboard write visible to stall_o the cycle after issue. Latency L operand: consumer issued back-to-back stalls exactly L cycles with hold_i=0.
- hold_i extends stalls cycle-for-cycle.
- Reset mid-operation: all counters 0 on the reset edge; perf counters 0; outputs as above.
- flush_i and issue_i same cycle: flush wins, scoreboard all zero.

## Configuration
- HAZARD_PERF_CNT_EN defined: perf_stall_cnt_o and perf_lu_cnt_o are 32-bit saturating counters, cleared by rst_i, not by flush_i, incrementing on cycles with stall_o=1 / load_use=1.
- Undefined: both ports present, tied to 0, no counter flops.

## Test plan
- Reset: rst_i=1, rf_rdata=32'hDEAD_BEEF, addr=3 -> rdata_o=0, stall_o=0, counters 0.
- Priority: EX/MEM/WB all write r5 with 1/2/3, vld=1 -> rdata=1; drop EX -> 2; drop MEM -> 3; addr 0 with WB r0 -> rf value.
- Load-use: EX we r7 vld=0, port1 used r7 -> stall_o=1, why=010; rd_used_i=0 -> stall_o=0.
- Scoreboard: issue r9 lat=3, hold_i=0, next instruction reads r9 -> stall exactly 3 cycles; with hold_i high 2 cycles in between -> 5 cycles.
- Branch: branch_i=1, EX we r4 vld=1, port0 r4 -> stall, why=100; branch_i=0 -> no stall, rdata=ex data.
- Flush/WAW: issue r2 lat=5, then r2 lat=1 -> stall 1 cycle; issue r2 lat=5 then flush_i -> no stall; with HAZARD_PERF_CNT_EN perf_stall_cnt_o equals stalled cycle count.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// ID-stage operand hazard unit: EX/MEM/WB forwarding plus a per-register countdown scoreboard.
// Optional HAZARD_PERF_CNT_EN macro enables the saturating stall/load-use performance counters.
module id_hazard_scoreboard #(
  parameter int NUM_RPORTS = 2,
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int MAX_LAT    = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_RPORTS*AW-1:0] rd_addr_i,
  input  logic [NUM_RPORTS-1:0]    rd_used_i,
  input  logic [NUM_RPORTS*DW-1:0] rf_rdata_i,
  output logic [NUM_RPORTS*DW-1:0] rdata_o,
  input  logic                     branch_i,
  input  logic                     ex_we_i,
  input  logic [AW-1:0]            ex_waddr_i,
  input  logic [DW-1:0]            ex_wdata_i,
  input  logic                     ex_vld_i,
  input  logic                     mem_we_i,
  input  logic [AW-1:0]            mem_waddr_i,
  input  logic [DW-1:0]            mem_wdata_i,
  input  logic                     mem_vld_i,
  input  logic                     wb_we_i,
  input  logic [AW-1:0]            wb_waddr_i,
  input  logic [DW-1:0]            wb_wdata_i,
  input  logic                     issue_i,
  input  logic                     issue_we_i,
  input  logic [AW-1:0]            issue_waddr_i,
  input  logic [2:0]               issue_lat_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic [2:0]               stall_why_o,
  output logic [31:0]              perf_stall_cnt_o,
  output logic [31:0]              perf_lu_cnt_o
);

  localparam int CW   = $clog2(MAX_LAT + 1);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0]       w_busy_vec;
  logic [NUM_RPORTS-1:0] w_lu_vec;
  logic [NUM_RPORTS-1:0] w_br_vec;
  logic [NUM_RPORTS-1:0] w_sb_vec;
  logic                  w_issue_wr;
  logic [CW-1:0]         w_issue_lat;

  assign w_issue_wr  = issue_i && issue_we_i && (issue_waddr_i != '0);
  assign w_issue_lat = (int'(issue_lat_i) > MAX_LAT) ? CW'(MAX_LAT) : CW'(issue_lat_i);

  // r0 is hard zero and never tracked.
  assign w_busy_vec[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        r_cnt <= '0;
      end else if (w_issue_wr && (issue_waddr_i == AW'(gi))) begin
        r_cnt <= w_issue_lat;
      end else if (!hold_i && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end

    assign w_busy_vec[gi] = (r_cnt != '0);
  end

  for (genvar gi = 0; gi < NUM_RPORTS; gi++) begin : g_port
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_rf;
    logic          w_nz;
    logic          w_ex_hit;
    logic          w_mem_hit;
    logic          w_wb_hit;
    logic [DW-1:0] w_rdata;

    assign w_addr    = rd_addr_i[gi*AW +: AW];
    assign w_rf      = rf_rdata_i[gi*DW +: DW];
    assign w_nz      = (w_addr != '0);
    assign w_ex_hit  = w_nz && ex_we_i  && (ex_waddr_i  == w_addr);
    assign w_mem_hit = w_nz && mem_we_i && (mem_waddr_i == w_addr);
    assign w_wb_hit  = w_nz && wb_we_i  && (wb_waddr_i  == w_addr);

    // A not-yet-valid younger match blocks older stages; the stall covers it.
    always_comb begin
      w_rdata = w_rf;
      if (rst_i) begin
        w_rdata = '0;
      end else if (w_ex_hit) begin
        if (ex_vld_i) w_rdata = ex_wdata_i;
      end else if (w_mem_hit) begin
        if (mem_vld_i) w_rdata = mem_wdata_i;
      end else if (w_wb_hit) begin
        w_rdata = wb_wdata_i;
      end
    end

    assign rdata_o[gi*DW +: DW] = w_rdata;
    assign w_lu_vec[gi] = rd_used_i[gi] && ((w_ex_hit && !ex_vld_i) || (w_mem_hit && !mem_vld_i));
    assign w_br_vec[gi] = rd_used_i[gi] && branch_i && w_ex_hit;
    assign w_sb_vec[gi] = rd_used_i[gi] && w_busy_vec[w_addr];
  end

  assign stall_why_o = rst_i ? 3'b000 : {|w_br_vec, |w_lu_vec, |w_sb_vec};
  assign stall_o     = |stall_why_o;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_lu;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_stall <= '0;
      r_perf_lu    <= '0;
    end else begin
      if (stall_o && (r_perf_stall != '1))        r_perf_stall <= r_perf_stall + 32'd1;
      if (stall_why_o[1] && (r_perf_lu != '1))    r_perf_lu    <= r_perf_lu + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_perf_stall;
  assign perf_lu_cnt_o    = r_perf_lu;
`else
  assign perf_stall_cnt_o = '0;
  assign perf_lu_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: stimulus queues expectations, a negedge monitor checks them.
module tb_id_hazard_scoreboard;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP*AW-1:0] rd_addr;
  logic [NP-1:0]  rd_used;
  logic [NP*DW-1:0] rf_rdata;
  logic [NP*DW-1:0] rdata;
  logic           branch;
  logic           ex_we, ex_vld, mem_we, mem_vld, wb_we;
  logic [AW-1:0]  ex_waddr, mem_waddr, wb_waddr, issue_waddr;
  logic [DW-1:0]  ex_wdata, mem_wdata, wb_wdata;
  logic           issue, issue_we, hold, flush;
  logic [2:0]     issue_lat;
  logic           stall;
  logic [2:0]     stall_why;
  logic [31:0]    perf_stall, perf_lu;

  always #5 clk = ~clk;

  id_hazard_scoreboard #(.NUM_RPORTS(NP), .DW(DW), .AW(AW), .MAX_LAT(7)) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_addr_i(rd_addr), .rd_used_i(rd_used), .rf_rdata_i(rf_rdata), .rdata_o(rdata),
    .branch_i(branch),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_vld_i(ex_vld),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata), .mem_vld_i(mem_vld),
    .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .issue_i(issue), .issue_we_i(issue_we), .issue_waddr_i(issue_waddr), .issue_lat_i(issue_lat),
    .hold_i(hold), .flush_i(flush),
    .stall_o(stall), .stall_why_o(stall_why),
    .perf_stall_cnt_o(perf_stall), .perf_lu_cnt_o(perf_lu)
  );

  // kind: 0 = {stall, why}, 1 = rdata of port, 2 = perf stall count, 3 = perf load-use count
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string n, input int k, input int p, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.port = p; e.val = v;
    q.push_back(e);
  endtask

  task automatic exp_st(input string n, input logic [2:0] why);
    push(n, 0, 0, {28'd0, (why != 3'b000), why});
  endtask

  task automatic exp_rd(input string n, input int p, input logic [31:0] v);
    push(n, 1, p, v);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.kind)
          0:       act = {28'd0, stall, stall_why};
          1:       act = rdata[e.port*DW +: DW];
          2:       act = perf_stall;
          default: act = perf_lu;
        endcase
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end else begin
          $display("ok   %s: %h", e.name, act);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rd_addr = '0; rd_used = '0; rf_rdata = '0; branch = 1'b0;
    ex_we = 1'b0; ex_vld = 1'b1; ex_waddr = '0; ex_wdata = '0;
    mem_we = 1'b0; mem_vld = 1'b1; mem_waddr = '0; mem_wdata = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    issue = 1'b0; issue_we = 1'b0; issue_waddr = '0; issue_lat = '0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input logic [AW-1:0] a, input logic [2:0] lat);
    issue = 1'b1; issue_we = 1'b1; issue_waddr = a; issue_lat = lat;
  endtask

  initial begin : stim
    logic [31:0] exp_ps, exp_pl;
    rst = 1'b1;
    clr();
    rd_addr = {5'd3, 5'd3}; rd_used = 2'b11; rf_rdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tick();
    exp_rd("reset_rd0", 0, 32'h0);
    exp_rd("reset_rd1", 1, 32'h0);
    exp_st("reset_stall", 3'b000);
    push("reset_perf_stall", 2, 0, 32'h0);
    push("reset_perf_lu", 3, 0, 32'h0);
    tick();
    rst = 1'b0; clr();
    tick();

    // forwarding priority EX > MEM > WB
    rd_addr = {5'd0, 5'd5}; rd_used = 2'b01; rf_rdata = {32'h1234, 32'h55};
    ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'd1;
    mem_we = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'd2;
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'd3;
    exp_rd("fwd_ex", 0, 32'd1); exp_st("fwd_ex_nostall", 3'b000);
    tick();
    ex_we = 1'b0;
    exp_rd("fwd_mem", 0, 32'd2);
    tick();
    mem_we = 1'b0;
    exp_rd("fwd_wb", 0, 32'd3);
    tick();
    wb_waddr = 5'd0;
    exp_rd("r0_rf", 1, 32'h1234);
    exp_rd("wb_r0_nohit", 0, 32'h55);
    tick();

    // load-use from EX and MEM
    clr();
    rd_addr = {5'd7, 5'd0}; rd_used = 2'b10;
    ex_we = 1'b1; ex_waddr = 5'd7; ex_vld = 1'b0; ex_wdata = 32'h77;
    exp_st("lu_ex", 3'b010);
    tick();
    rd_used = 2'b00;
    exp_st("lu_unused", 3'b000);
    tick();
    rd_used = 2'b10; ex_we = 1'b0;
    mem_we = 1'b1; mem_waddr = 5'd7; mem_vld = 1'b0; mem_wdata = 32'h99;
    exp_st("lu_mem", 3'b010);
    tick();
    mem_vld = 1'b1;
    exp_st("mem_valid_nostall", 3'b000);
    exp_rd("mem_valid_fwd", 1, 32'h99);
    tick();

    // branch needing EX result
    clr();
    rd_addr = {5'd0, 5'd4}; rd_used = 2'b01;
    branch = 1'b1; ex_we = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'hAB;
    exp_st("branch_ex", 3'b100);
    tick();
    branch = 1'b0;
    exp_st("nobranch", 3'b000);
    exp_rd("nobranch_fwd", 0, 32'hAB);
    tick();
    branch = 1'b1; ex_vld = 1'b0;
    exp_st("branch_and_lu", 3'b110);
    tick();

    // scoreboard latency 3, no hold
    clr();
    do_issue(5'd9, 3'd3);
    tick();
    clr();
    rd_addr = {5'd0, 5'd9}; rd_used = 2'b01;
    for (int i = 0; i < 3; i++) begin
      exp_st("sb_lat3", 3'b001);
      tick();
    end
    exp_st("sb_lat3_done", 3'b000);
    tick();

    // same, with two hold cycles
    clr();
    do_issue(5'd9, 3'd3);
    tick();
    clr();
    rd_addr = {5'd0, 5'd9}; rd_used = 2'b01;
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_st("sb_hold", 3'b001);
      tick();
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_st("sb_hold_drain", 3'b001);
      tick();
    end
    exp_st("sb_hold_done", 3'b000);
    tick();

    // fresh reset, then WAW / flush, with perf counter check at the end
    rst = 1'b1; clr();
    tick();
    rst = 1'b0;
    tick();
    do_issue(5'd2, 3'd5);
    tick();
    do_issue(5'd2, 3'd1);
    tick();
    clr();
    rd_addr = {5'd0, 5'd2}; rd_used = 2'b01;
    exp_st("waw_stall", 3'b001);
    tick();
    exp_st("waw_done", 3'b000);
    tick();
    clr();
    do_issue(5'd2, 3'd5);
    tick();
    clr(); flush = 1'b1;
    tick();
    clr();
    rd_addr = {5'd0, 5'd2}; rd_used = 2'b01;
    exp_st("flush_clears", 3'b000);
    tick();
    clr();
    do_issue(5'd3, 3'd5); flush = 1'b1;
    tick();
    clr();
    rd_addr = {5'd0, 5'd3}; rd_used = 2'b01;
    exp_st("flush_beats_issue", 3'b000);
    tick();
    clr();
    rd_addr = {5'd7, 5'd2}; rd_used = 2'b11;
    ex_we = 1'b1; ex_waddr = 5'd7; ex_vld = 1'b0;
    exp_st("lu_for_perf", 3'b010);
    tick();
    clr();
`ifdef HAZARD_PERF_CNT_EN
    exp_ps = 32'd2; exp_pl = 32'd1;
`else
    exp_ps = 32'd0; exp_pl = 32'd0;
`endif
    push("perf_stall", 2, 0, exp_ps);
    push("perf_lu", 3, 0, exp_pl);
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
